// File: rtl/pll_reset_sequencer.sv
`timescale 1ns / 1ps
// ---------------------------------------------------------------------------
// pll_reset_sequencer
//
// Brings up the iCE40 PLL and the reset of the PLL-derived clock domain.
// Holds the PLL in reset for a fixed time, waits (bounded) for LOCK, requires
// LOCK to stay up for a stable window, then releases the system reset.
// A lock loss while running re-runs the whole sequence; too many failed
// lock attempts park the block in FAULT until restart or resetn.
// Runs entirely on the always-running 48 MHz reference clock.
//
// Parameters:
//   RESET_CYCLES  - cycles pll_resetb is held low per attempt (>=1)
//   LOCK_TIMEOUT  - cycles to wait for synchronized lock per attempt
//   STABLE_CYCLES - consecutive synchronized-lock cycles before release
//   MAX_RETRIES   - failed attempts tolerated before FAULT (>=1, <=3)
//
// Ports:
//   clock_in   in   48 MHz reference clock (same net as PLL REFERENCECLK)
//   resetn     in   asynchronous active-low reset
//   pll_locked in   PLL LOCK, asynchronous to clock_in
//   restart    in   synchronous one-cycle request to re-run the sequence
//   pll_resetb out  to PLL RESETB, 0 holds the PLL in reset
//   sys_resetn out  active-low reset for the PLL clock domain
//   ready      out  1 only while running
//   fault      out  1 only in FAULT
//   retries    out  failed lock attempts in the current sequence
//   loss_count out  lock-loss events while running, saturating at 255
// ---------------------------------------------------------------------------
module pll_reset_sequencer #(
   parameter int RESET_CYCLES  = 16,
   parameter int LOCK_TIMEOUT  = 4800,
   parameter int STABLE_CYCLES = 256,
   parameter int MAX_RETRIES   = 3
) (
   input  logic       clock_in,
   input  logic       resetn,
   input  logic       pll_locked,
   input  logic       restart,
   output logic       pll_resetb,
   output logic       sys_resetn,
   output logic       ready,
   output logic       fault,
   output logic [1:0] retries,
   output logic [7:0] loss_count
);

   // The shared counter only has to reach the largest terminal count minus
   // one, so clog2 of the largest cycle parameter is always wide enough.
   localparam int MAX_AB  = (RESET_CYCLES > LOCK_TIMEOUT) ? RESET_CYCLES : LOCK_TIMEOUT;
   localparam int CNT_MAX = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   localparam logic [CNT_W-1:0] RESET_LAST   = CNT_W'(RESET_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [1:0]       RETRY_LIMIT  = 2'(MAX_RETRIES);

   typedef enum logic [2:0] {
      ST_HOLD,
      ST_WAIT,
      ST_SETTLE,
      ST_RUN,
      ST_FAULT
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_next;
   logic             lock_meta;
   logic             lock_s;
   logic [1:0]       retries_next;
   logic [1:0]       retries_inc;
   logic [7:0]       loss_next;
   logic [7:0]       loss_inc;
   logic             pll_resetb_next;
   logic             run_next;
   logic             fault_next;

   // Two-flop synchronizer for the asynchronous PLL LOCK. Every decision in
   // the state machine looks at lock_s only, never at pll_locked directly.
   always_ff @(posedge clock_in or negedge resetn) begin
      if (!resetn) begin
         lock_meta <= 1'b0;
         lock_s    <= 1'b0;
      end else begin
         lock_meta <= pll_locked;
         lock_s    <= lock_meta;
      end
   end

   // Saturating increments; retries stops at the limit, loss_count at 255.
   always_comb begin
      retries_inc = (retries >= RETRY_LIMIT) ? retries : retries + 2'd1;
      loss_inc    = (loss_count == 8'hFF) ? loss_count : loss_count + 8'd1;
   end

   // Next-state logic. The per-state transitions are evaluated first and a
   // restart request then overrides all of them, so restart always wins.
   always_comb begin
      state_next   = state;
      retries_next = retries;
      loss_next    = loss_count;

      case (state)
         ST_HOLD: begin
            if (cnt == RESET_LAST) begin
               state_next = ST_WAIT;
            end
         end
         ST_WAIT: begin
            // Lock seen on the timeout cycle still counts as lock.
            if (lock_s) begin
               state_next = ST_SETTLE;
            end else if (cnt == TIMEOUT_LAST) begin
               retries_next = retries_inc;
               state_next   = (retries_inc == RETRY_LIMIT) ? ST_FAULT : ST_HOLD;
            end
         end
         ST_SETTLE: begin
            // Losing lock before the window completes is not a failed
            // attempt; just go back to waiting with a fresh timeout.
            if (!lock_s) begin
               state_next = ST_WAIT;
            end else if (cnt == STABLE_LAST) begin
               state_next = ST_RUN;
            end
         end
         ST_RUN: begin
            if (!lock_s) begin
               loss_next    = loss_inc;
               retries_next = 2'd0;
               state_next   = ST_HOLD;
            end
         end
         ST_FAULT: begin
            state_next = ST_FAULT;
         end
         default: begin
            state_next = ST_HOLD;
         end
      endcase

      if (restart) begin
         state_next   = ST_HOLD;
         retries_next = 2'd0;
         loss_next    = loss_count;
      end
   end

   // Shared counter: cleared on every state change (a restart counts as one
   // even when already in HOLD), counting only in states with a terminal
   // count so it can never wrap while parked in RUN or FAULT.
   always_comb begin
      cnt_next = cnt;
      if (restart || (state_next != state)) begin
         cnt_next = '0;
      end else if ((state == ST_HOLD) || (state == ST_WAIT) || (state == ST_SETTLE)) begin
         cnt_next = cnt + CNT_W'(1);
      end
   end

   // Outputs are decoded from the next state so that, once registered, they
   // change on the same edge as the state register.
   always_comb begin
      pll_resetb_next = 1'b1;
      run_next        = 1'b0;
      fault_next      = 1'b0;
      case (state_next)
         ST_HOLD:  pll_resetb_next = 1'b0;
         ST_FAULT: begin
            pll_resetb_next = 1'b0;
            fault_next      = 1'b1;
         end
         ST_RUN:   run_next = 1'b1;
         default:  pll_resetb_next = 1'b1;
      endcase
   end

   // State, counter, statistics and registered outputs.
   always_ff @(posedge clock_in or negedge resetn) begin
      if (!resetn) begin
         state      <= ST_HOLD;
         cnt        <= '0;
         retries    <= 2'd0;
         loss_count <= 8'd0;
         pll_resetb <= 1'b0;
         sys_resetn <= 1'b0;
         ready      <= 1'b0;
         fault      <= 1'b0;
      end else begin
         state      <= state_next;
         cnt        <= cnt_next;
         retries    <= retries_next;
         loss_count <= loss_next;
         pll_resetb <= pll_resetb_next;
         sys_resetn <= run_next;
         ready      <= run_next;
         fault      <= fault_next;
      end
   end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
`timescale 1ns / 1ps
// ---------------------------------------------------------------------------
// tb_pll_reset_sequencer
//
// Directed bench for pll_reset_sequencer with small cycle parameters.
// Inputs change and outputs are sampled on the falling clock edge; the DUT
// acts on the rising edge. Expected cycle counts are worked out by hand
// from the sequencing rules (2 synchronizer flops + 1 state register).
// ---------------------------------------------------------------------------
module tb_pll_reset_sequencer;

   localparam int RESET_CYCLES  = 4;
   localparam int LOCK_TIMEOUT  = 20;
   localparam int STABLE_CYCLES = 8;
   localparam int MAX_RETRIES   = 2;
   localparam int LIMIT         = 200;

   logic       clock_in = 1'b0;
   logic       resetn;
   logic       pll_locked;
   logic       restart;
   logic       pll_resetb;
   logic       sys_resetn;
   logic       ready;
   logic       fault;
   logic [1:0] retries;
   logic [7:0] loss_count;

   int   total = 0;
   int   bad   = 0;
   int   n;
   int   exp_loss;
   logic sys_seen;

   pll_reset_sequencer #(
      .RESET_CYCLES (RESET_CYCLES),
      .LOCK_TIMEOUT (LOCK_TIMEOUT),
      .STABLE_CYCLES(STABLE_CYCLES),
      .MAX_RETRIES  (MAX_RETRIES)
   ) dut (
      .clock_in  (clock_in),
      .resetn    (resetn),
      .pll_locked(pll_locked),
      .restart   (restart),
      .pll_resetb(pll_resetb),
      .sys_resetn(sys_resetn),
      .ready     (ready),
      .fault     (fault),
      .retries   (retries),
      .loss_count(loss_count)
   );

   // 100 MHz-style bench clock; only relative cycle counts matter here.
   always #5 clock_in = ~clock_in;

   // Drive all DUT inputs in one place.
   task applyStimulus(input logic rst_v, input logic lock_v, input logic restart_v);
      resetn     = rst_v;
      pll_locked = lock_v;
      restart    = restart_v;
   endtask

   // Single comparison point: counts every check and reports mismatches.
   task checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   // Selects which output a bounded wait watches.
   function automatic logic pick(input int sel);
      case (sel)
         0:       return pll_resetb;
         1:       return sys_resetn;
         2:       return fault;
         default: return ready;
      endcase
   endfunction

   // Counts falling edges until the selected output reaches the level, or
   // LIMIT is reached (the caller's exact comparison then flags it).
   task countUntil(input int sel, input logic level, output int cnt);
      cnt = 0;
      do begin
         @(negedge clock_in);
         cnt++;
         if (sys_resetn === 1'b1) sys_seen = 1'b1;
      end while ((pick(sel) !== level) && (cnt < LIMIT));
   endtask

   initial begin
      // ---- reset values, lock already high ---------------------------------
      applyStimulus(1'b0, 1'b1, 1'b0);
      repeat (3) @(negedge clock_in);
      checkOutput("rst pll_resetb", 32'(pll_resetb), 0);
      checkOutput("rst sys_resetn", 32'(sys_resetn), 0);
      checkOutput("rst ready",      32'(ready),      0);
      checkOutput("rst fault",      32'(fault),      0);
      checkOutput("rst retries",    32'(retries),    0);
      checkOutput("rst loss_count", 32'(loss_count), 0);

      // ---- 1: lock tied high -----------------------------------------------
      // Synchronizer is already full by the time WAIT is entered, so SETTLE
      // follows on the next edge and RUN one stable window later.
      applyStimulus(1'b1, 1'b1, 1'b0);
      countUntil(0, 1'b1, n);
      checkOutput("t1 hold edges", 32'(n), 32'(RESET_CYCLES));
      countUntil(1, 1'b1, n);
      checkOutput("t1 run edges", 32'(n), 32'(1 + STABLE_CYCLES));
      checkOutput("t1 ready",   32'(ready),   1);
      checkOutput("t1 retries", 32'(retries), 0);
      checkOutput("t1 fault",   32'(fault),   0);

      // ---- 2: lock never comes, two attempts then FAULT --------------------
      applyStimulus(1'b0, 1'b0, 1'b0);
      @(negedge clock_in);
      checkOutput("t2 async rst ready", 32'(ready), 0);
      applyStimulus(1'b1, 1'b0, 1'b0);
      sys_seen = 1'b0;
      countUntil(0, 1'b1, n);
      checkOutput("t2 hold1 edges", 32'(n), 32'(RESET_CYCLES));
      countUntil(0, 1'b0, n);
      checkOutput("t2 wait1 edges", 32'(n), 32'(LOCK_TIMEOUT));
      checkOutput("t2 retries 1",   32'(retries), 1);
      checkOutput("t2 fault early", 32'(fault),   0);
      countUntil(0, 1'b1, n);
      checkOutput("t2 hold2 edges", 32'(n), 32'(RESET_CYCLES));
      countUntil(2, 1'b1, n);
      checkOutput("t2 wait2 edges",  32'(n), 32'(LOCK_TIMEOUT));
      checkOutput("t2 retries 2",    32'(retries), 32'(MAX_RETRIES));
      checkOutput("t2 pll_resetb",   32'(pll_resetb), 0);
      checkOutput("t2 sys_resetn",   32'(sys_resetn), 0);
      checkOutput("t2 sys never up", 32'(sys_seen),   0);
      repeat (5) @(negedge clock_in);
      checkOutput("t2 fault sticky", 32'(fault), 1);

      // ---- 3: restart out of FAULT -----------------------------------------
      applyStimulus(1'b1, 1'b0, 1'b1);
      @(negedge clock_in);
      applyStimulus(1'b1, 1'b1, 1'b0);
      checkOutput("t3 fault clr",  32'(fault),      0);
      checkOutput("t3 retries",    32'(retries),    0);
      checkOutput("t3 pll_resetb", 32'(pll_resetb), 0);
      countUntil(0, 1'b1, n);
      checkOutput("t3 hold edges", 32'(n), 32'(RESET_CYCLES));
      countUntil(1, 1'b1, n);
      checkOutput("t3 run edges", 32'(n), 32'(1 + STABLE_CYCLES));
      checkOutput("t3 ready",     32'(ready), 1);

      // ---- 4: lock loss in RUN for 5 cycles --------------------------------
      applyStimulus(1'b1, 1'b0, 1'b0);
      countUntil(1, 1'b0, n);
      checkOutput("t4 loss latency", 32'(n), 3);
      checkOutput("t4 loss_count",   32'(loss_count), 1);
      checkOutput("t4 pll_resetb",   32'(pll_resetb), 0);
      checkOutput("t4 ready",        32'(ready),      0);
      repeat (2) @(negedge clock_in);
      applyStimulus(1'b1, 1'b1, 1'b0);
      // HOLD entered 2 edges before lock returned; 2 more edges remain.
      countUntil(0, 1'b1, n);
      checkOutput("t4 hold rest", 32'(n), 2);
      countUntil(1, 1'b1, n);
      checkOutput("t4 rerun edges", 32'(n), 32'(1 + STABLE_CYCLES));
      checkOutput("t4 retries",     32'(retries), 0);

      // ---- 5: lock dip during SETTLE ---------------------------------------
      applyStimulus(1'b1, 1'b1, 1'b1);
      @(negedge clock_in);
      applyStimulus(1'b1, 1'b1, 1'b0);
      checkOutput("t5 restart sys", 32'(sys_resetn), 0);
      repeat (RESET_CYCLES + 1 + 5) @(negedge clock_in);
      checkOutput("t5 settle resetb", 32'(pll_resetb), 1);
      checkOutput("t5 settle sys",    32'(sys_resetn), 0);
      applyStimulus(1'b1, 1'b0, 1'b0);
      repeat (3) @(negedge clock_in);
      // Undisturbed, RUN would have been entered on the last of these edges.
      checkOutput("t5 no run",     32'(sys_resetn), 0);
      checkOutput("t5 no retry",   32'(retries),    0);
      checkOutput("t5 pll up",     32'(pll_resetb), 1);
      applyStimulus(1'b1, 1'b1, 1'b0);
      countUntil(1, 1'b1, n);
      checkOutput("t5 fresh window", 32'(n), 32'(2 + 1 + STABLE_CYCLES));
      checkOutput("t5 loss kept",    32'(loss_count), 1);

      // ---- 6: loss_count saturation ----------------------------------------
      exp_loss = 1;
      for (int i = 0; i < 260; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b0);
         countUntil(1, 1'b0, n);
         applyStimulus(1'b1, 1'b1, 1'b0);
         countUntil(1, 1'b1, n);
         exp_loss = (exp_loss < 255) ? exp_loss + 1 : 255;
         if ((exp_loss >= 254) || ((i % 64) == 0)) begin
            checkOutput("t6 loss_count", 32'(loss_count), 32'(exp_loss));
         end
      end
      checkOutput("t6 ready", 32'(ready), 1);

      // ---- 6b: asynchronous reset mid-SETTLE -------------------------------
      applyStimulus(1'b1, 1'b1, 1'b1);
      @(negedge clock_in);
      applyStimulus(1'b1, 1'b1, 1'b0);
      repeat (RESET_CYCLES + 2) @(negedge clock_in);
      checkOutput("t6 settle resetb", 32'(pll_resetb), 1);
      #2;
      applyStimulus(1'b0, 1'b1, 1'b0);
      #1;
      checkOutput("t6 arst pll_resetb", 32'(pll_resetb), 0);
      checkOutput("t6 arst sys_resetn", 32'(sys_resetn), 0);
      checkOutput("t6 arst ready",      32'(ready),      0);
      checkOutput("t6 arst fault",      32'(fault),      0);
      checkOutput("t6 arst retries",    32'(retries),    0);
      checkOutput("t6 arst loss_count", 32'(loss_count), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
